// File: rtl/kf6845_vertical_control.sv
// KF6845 CRTC vertical timing: scan-line / character-row counters, vertical display enable and VSYNC.
// Counters and VSYNC move one clock after a qualified Horizontal_End; Vertical_End and V_Display are combinational.
module kf6845_vertical_control (
    input  logic       clock,
    input  logic       reset,
    input  logic       video_clock_enable,
    input  logic [7:0] internal_data_bus,
    input  logic       write_vertical_total_register,
    input  logic       write_vertical_total_adjust_register,
    input  logic       write_vertical_displayed_register,
    input  logic       write_vertical_sync_position_register,
    input  logic       write_maximum_scan_line_register,
    input  logic       Horizontal_End,
    output logic [4:0] row_address,
    output logic [6:0] vertical_row_counter,
    output logic       V_Display,
    output logic       VSYNC,
    output logic       Vertical_End
);

    typedef enum logic {ROWS, ADJUST} state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] vertical_total;
    logic [4:0] vertical_total_adjust;
    logic [6:0] vertical_displayed;
    logic [6:0] vertical_sync_position;
    logic [4:0] maximum_scan_line;
    logic [3:0] sync_count;

    logic       adv;
    logic       ra_at_max;
    logic       row_at_total;
    logic       adjust_last;
    logic       frame_end;
    logic       sync_trigger;
    logic [4:0] next_ra;
    logic [6:0] next_row;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vertical_total         <= 7'd0;
            vertical_total_adjust  <= 5'd0;
            vertical_displayed     <= 7'd0;
            vertical_sync_position <= 7'd0;
            maximum_scan_line      <= 5'd0;
        end else begin
            if (write_vertical_total_register)         vertical_total         <= internal_data_bus[6:0];
            if (write_vertical_total_adjust_register)  vertical_total_adjust  <= internal_data_bus[4:0];
            if (write_vertical_displayed_register)     vertical_displayed     <= internal_data_bus[6:0];
            if (write_vertical_sync_position_register) vertical_sync_position <= internal_data_bus[6:0];
            if (write_maximum_scan_line_register)      maximum_scan_line      <= internal_data_bus[4:0];
        end
    end

    assign adv          = video_clock_enable & Horizontal_End;
    assign ra_at_max    = (row_address == maximum_scan_line);
    assign row_at_total = (vertical_row_counter == vertical_total);
    // In ADJUST the adjust lines are numbered 0..R5-1; a short rewrite lets RA wrap at 5 bits.
    assign adjust_last  = (row_address == (vertical_total_adjust - 5'd1));

    always_comb begin
        next_state = state;
        next_ra    = row_address + 5'd1;
        next_row   = vertical_row_counter;
        frame_end  = 1'b0;
        case (state)
            ROWS: begin
                if (ra_at_max) begin
                    next_ra = 5'd0;
                    if (!row_at_total) begin
                        next_row = vertical_row_counter + 7'd1;
                    end else if (vertical_total_adjust == 5'd0) begin
                        next_row  = 7'd0;
                        frame_end = 1'b1;
                    end else begin
                        next_state = ADJUST;
                    end
                end
            end
            ADJUST: begin
                if (adjust_last) begin
                    next_state = ROWS;
                    next_ra    = 5'd0;
                    next_row   = 7'd0;
                    frame_end  = 1'b1;
                end
            end
            default: next_state = ROWS;
        endcase
    end

    assign Vertical_End = adv & frame_end;
    assign V_Display    = (state == ROWS) && (vertical_row_counter < vertical_displayed);
    assign sync_trigger = adv && (next_state == ROWS) && (next_row == vertical_sync_position)
                          && (next_ra == 5'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= ROWS;
            row_address          <= 5'd0;
            vertical_row_counter <= 7'd0;
            VSYNC                <= 1'b0;
            sync_count           <= 4'd0;
        end else begin
            if (adv) begin
                state                <= next_state;
                row_address          <= next_ra;
                vertical_row_counter <= next_row;
            end
            // Sync width is counted in lines, independent of frame boundaries.
            if (VSYNC) begin
                if (adv) begin
                    sync_count <= sync_count + 4'd1;
                    if (sync_count == 4'd15) VSYNC <= 1'b0;
                end
            end else if (sync_trigger) begin
                VSYNC      <= 1'b1;
                sync_count <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_kf6845_vertical_control.sv
// Directed bench for kf6845_vertical_control: line-by-line checks of counters, display, sync and frame end.
module tb_kf6845_vertical_control;

    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       video_clock_enable = 1'b0;
    logic [7:0] internal_data_bus = 8'd0;
    logic       w4 = 1'b0, w5 = 1'b0, w6 = 1'b0, w7 = 1'b0, w9 = 1'b0;
    logic       Horizontal_End = 1'b0;
    logic [4:0] row_address;
    logic [6:0] vertical_row_counter;
    logic       V_Display;
    logic       VSYNC;
    logic       Vertical_End;

    int errors = 0;
    int checks = 0;

    kf6845_vertical_control dut (
        .clock                                 (clock),
        .reset                                 (reset),
        .video_clock_enable                    (video_clock_enable),
        .internal_data_bus                     (internal_data_bus),
        .write_vertical_total_register         (w4),
        .write_vertical_total_adjust_register  (w5),
        .write_vertical_displayed_register     (w6),
        .write_vertical_sync_position_register (w7),
        .write_maximum_scan_line_register      (w9),
        .Horizontal_End                        (Horizontal_End),
        .row_address                           (row_address),
        .vertical_row_counter                  (vertical_row_counter),
        .V_Display                             (V_Display),
        .VSYNC                                 (VSYNC),
        .Vertical_End                          (Vertical_End)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int ra, input int row, input bit vd,
                               input bit chk_vs, input bit vs, input bit vend);
        chk({tag, ".ra"}, {27'd0, row_address}, ra);
        chk({tag, ".row"}, {25'd0, vertical_row_counter}, row);
        chk({tag, ".vdisp"}, {31'd0, V_Display}, {31'd0, vd});
        if (chk_vs) chk({tag, ".vsync"}, {31'd0, VSYNC}, {31'd0, vs});
        chk({tag, ".vend"}, {31'd0, Vertical_End}, {31'd0, vend});
    endtask

    // Called just after a rising edge; checks the current line during its Horizontal_End cycle.
    task automatic line_step(input string tag, input int ra, input int row, input bit vd,
                             input bit chk_vs, input bit vs, input bit vend);
        Horizontal_End     = 1'b1;
        video_clock_enable = 1'b1;
        @(negedge clock);
        chk_outputs(tag, ra, row, vd, chk_vs, vs, vend);
        @(posedge clock); #1;
        Horizontal_End = 1'b0;
        repeat (GAP) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wreg(input int idx, input logic [7:0] d);
        internal_data_bus = d;
        w4 = (idx == 4);
        w5 = (idx == 5);
        w6 = (idx == 6);
        w7 = (idx == 7);
        w9 = (idx == 9);
        @(posedge clock); #1;
        {w4, w5, w6, w7, w9} = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic config_std(input logic [7:0] r5);
        wreg(9, 8'hE7);   // high bits ignored -> 7
        wreg(4, 8'h83);   // -> 3
        wreg(5, r5);
        wreg(6, 8'd2);
        wreg(7, 8'd3);
    endtask

    initial begin
        int f;
        #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk_outputs("reset", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // All registers zero: every line ends the frame; sync restarts after a one-line gap.
        for (int k = 0; k < 20; k++) begin
            line_step($sformatf("zero[%0d]", k), 0, 0, 1'b0, 1'b1,
                      ((k >= 1 && k <= 16) || k >= 18), 1'b1);
        end

        // 34-line frame with two adjust lines; sync spans the frame wrap.
        do_reset();
        config_std(8'd2);
        for (int n = 0; n < 76; n++) begin
            f = n % 34;
            line_step($sformatf("adj[%0d]", n),
                      (f < 32) ? f % 8 : f - 32,
                      (f < 32) ? f / 8 : 3,
                      (f < 16), 1'b1,
                      ((n >= 24 && n < 40) || (n >= 58 && n < 74)),
                      (f == 33));
        end

        // No adjust: 32-line frame, row 3 RA 7 wraps straight to row 0.
        do_reset();
        config_std(8'd0);
        for (int n = 0; n < 41; n++) begin
            f = n % 32;
            line_step($sformatf("noadj[%0d]", n), f % 8, f / 8, (f < 16), 1'b1,
                      (n >= 24 && n < 40), (f == 31));
        end

        // Reset while in ADJUST with sync active.
        do_reset();
        config_std(8'd2);
        for (int n = 0; n < 32; n++) begin
            line_step("pre", n % 8, n / 8, (n < 16), 1'b0, 1'b0, 1'b0);
        end
        @(negedge clock);
        chk_outputs("in_adjust", 0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk_outputs("async_rst", 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        line_step("post0", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        line_step("post1", 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Shrink R4 below the current row: counter runs to 127 and wraps to end at row 1.
        do_reset();
        config_std(8'd0);
        for (int n = 0; n < 16; n++) begin
            line_step("lead", n % 8, n / 8, (n < 16), 1'b0, 1'b0, 1'b0);
        end
        wreg(4, 8'd1);
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) begin
                Horizontal_End     = 1'b1;
                video_clock_enable = 1'b0;
                @(negedge clock);
                chk_outputs("ce_low", 7, 1, 1'b1, 1'b0, 1'b0, 1'b0);
                @(posedge clock); #1;
                Horizontal_End     = 1'b0;
                video_clock_enable = 1'b1;
                @(negedge clock);
                chk_outputs("ce_low_hold", 7, 1, 1'b1, 1'b0, 1'b0, 1'b0);
                @(posedge clock); #1;
            end
            line_step($sformatf("wrap[%0d]", i), i % 8, (2 + i / 8) % 128,
                      (((2 + i / 8) % 128) < 2), 1'b0, 1'b0, (i == 1023));
        end
        @(negedge clock);
        chk_outputs("wrap_end", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
